// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes decoded from Funct 0x18-0x1B,
// FSM states and the iteration count.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    localparam int MDU_STEPS = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply (multiplier LSB first) or restoring divide
// (quotient MSB first) on a shared 2*WIDTH accumulator.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Divide leaves the LSB of acc_next clear; the caller inserts q_bit there.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{acc[0]}}};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        trial    = shifted - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = '0;
        if (is_div) begin
            q_bit    = ~trial[WIDTH];
            acc_next = {(q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit producing HI/LO with a start/busy/done handshake.
// Magnitudes are iterated unsigned; the sign correction is applied in the FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MDU_STEPS);

    mdu_state_t         state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               res_neg;
    logic               rem_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;

    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // A zero divisor naturally leaves |in1| as the remainder, so only LO needs forcing.
    always_comb begin
        sign1   = op_is_signed(op) & in1[WIDTH-1];
        sign2   = op_is_signed(op) & in2[WIDTH-1];
        mag1    = sign1 ? -in1 : in1;
        mag2    = sign2 ? -in2 : in2;
        product = res_neg ? -acc : acc;
        rem_fix = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        quo_fix = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi  = product[2*WIDTH-1:WIDTH];
        fix_lo  = product[WIDTH-1:0];
        if (is_div) begin
            fix_hi = rem_fix;
            fix_lo = div_zero ? {WIDTH{1'b1}} : quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= MDU_IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (hi_we) hi <= in1;
                    if (lo_we) lo <= in1;
                    if (start) begin
                        is_div   <= op_is_div(op);
                        res_neg  <= sign1 ^ sign2;
                        rem_neg  <= sign1;
                        div_zero <= op_is_div(op) && (in2 == '0);
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= MDU_CALC;
                        if (op_is_div(op)) begin
                            operand <= mag2;
                            acc     <= {{WIDTH{1'b0}}, mag1};
                        end else begin
                            operand <= mag1;
                            acc     <= {{WIDTH{1'b0}}, mag2};
                        end
                    end
                end
                MDU_CALC: begin
                    acc   <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
                    count <= count + CW'(1);
                    if (count == CW'(MDU_STEPS - 1)) state <= MDU_FIX;
                end
                MDU_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed handshake/edge steps followed by
// random operations checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference result {HI, LO} from ordinary signed/unsigned arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] up;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MDU_MULT: begin
                sq = sa * sb;
                return sq;
            end
            MDU_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Leaves the bench at the first negedge after the start-sampling edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(negedge clk);
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
    endtask

    task automatic waitDone(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] expected);
        int lat;
        applyStimulus(o, a, b);
        checkOutput({tag, " busy"}, 64'(busy), 64'd1);
        waitDone(1, lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'd34);
        checkOutput({tag, " busy@done"}, 64'(busy), 64'd0);
        checkOutput({tag, " hi"}, 64'(hi), 64'(expected[63:32]));
        checkOutput({tag, " lo"}, 64'(lo), 64'(expected[31:0]));
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          lat;
        int          dones;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [31:0] edges [6];

        edges[0] = 32'h0000_0000;
        edges[1] = 32'hFFFF_FFFF;
        edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF;
        edges[4] = 32'h0000_0001;
        edges[5] = 32'hFFFF_FFFE;

        reset = 1'b0;
        start = 1'b0;
        op    = MDU_MULT;
        in1   = '0;
        in2   = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        reset = 1'b1;

        $display("[TB] MTHI / MTLO in IDLE");
        hi_we = 1'b1;
        in1   = 32'h0000_1234;
        @(negedge clk);
        checkOutput("mthi", 64'(hi), 64'h1234);
        hi_we = 1'b0;
        lo_we = 1'b1;
        in1   = 32'h0000_5678;
        @(negedge clk);
        checkOutput("mtlo", 64'(lo), 64'h5678);
        lo_we = 1'b0;

        $display("[TB] directed arithmetic");
        runAndCheck("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    64'hFFFF_FFFE_0000_0001);
        runAndCheck("mult -3*7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        runAndCheck("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        runAndCheck("divu /0", MDU_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        runAndCheck("div -9/0", MDU_DIV, 32'hFFFF_FFF7, 32'd0, 64'hFFFF_FFF7_FFFF_FFFF);
        runAndCheck("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                    64'h0000_0000_8000_0000);
        runAndCheck("div 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

        $display("[TB] start while busy is ignored");
        applyStimulus(MDU_MULTU, 32'd5, 32'd9);
        dones = 0;
        for (int k = 1; k <= 50; k++) begin
            if (done === 1'b1) dones++;
            start = (k == 4) || (k == 9);
            op    = MDU_DIVU;
            in1   = $urandom;
            in2   = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("double start dones", 64'(dones), 64'd1);
        checkOutput("double start hi", 64'(hi), 64'd0);
        checkOutput("double start lo", 64'(lo), 64'd45);

        $display("[TB] MTLO while busy is ignored");
        applyStimulus(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        lo_we = 1'b1;
        in1   = 32'h0000_DEAD;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo busy lo", 64'(lo), 64'd45);
        waitDone(2, lat);
        checkOutput("mtlo busy latency", 64'(lat), 64'd34);
        checkOutput("mtlo busy hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mtlo busy lo result", 64'(lo), 64'hFFFF_FFEB);

        $display("[TB] MTHI together with start");
        @(negedge clk);
        start = 1'b1;
        hi_we = 1'b1;
        op    = MDU_MULTU;
        in1   = 32'd6;
        in2   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        checkOutput("mthi+start hi", 64'(hi), 64'd6);
        checkOutput("mthi+start busy", 64'(busy), 64'd1);
        waitDone(1, lat);
        checkOutput("mthi+start latency", 64'(lat), 64'd34);
        checkOutput("mthi+start hi result", 64'(hi), 64'd0);
        checkOutput("mthi+start lo result", 64'(lo), 64'd42);

        $display("[TB] back-to-back operations");
        applyStimulus(MDU_MULTU, 32'h0000_FFFF, 32'h0001_0001);
        waitDone(1, lat);
        checkOutput("b2b first latency", 64'(lat), 64'd34);
        checkOutput("b2b first lo", 64'(lo), 64'hFFFF_FFFF);
        start = 1'b1;
        op    = MDU_DIVU;
        in1   = 32'd1000;
        in2   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b no gap busy", 64'(busy), 64'd1);
        waitDone(1, lat);
        checkOutput("b2b second latency", 64'(lat), 64'd34);
        checkOutput("b2b second hi", 64'(hi), 64'd6);
        checkOutput("b2b second lo", 64'(lo), 64'd142);

        $display("[TB] reset mid-operation");
        applyStimulus(MDU_DIVU, 32'h1234_5678, 32'h0000_1234);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset hi", 64'(hi), 64'd0);
        checkOutput("midreset lo", 64'(lo), 64'd0);
        reset = 1'b1;
        runAndCheck("after reset 6*7", MDU_MULTU, 32'd6, 32'd7, 64'd42);

        $display("[TB] random operations against reference model");
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            runAndCheck($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, refModel(ro, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit in the EX stage, beside the ALU; consumes the same two register operands (`in1`, `in2`) and produces the HI/LO pair for MULT/MULTU/DIV/DIVU and MTHI/MTLO. It runs one radix-2 step per clock and uses a start/busy/done handshake, so the controller stalls while `busy` is high. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `in1`  in  WIDTH  multiplicand / dividend (rs).
- `in2`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`  in  1  MTHI: write `in1` into HI.
- `lo_we`  in  1  MTLO: write `in1` into LO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when the result is committed.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE → CALC → FIX → IDLE.
- **IDLE**
  - If `start`=1: latch `op`, latch |in1| and |in2| (absolute values for signed ops, raw values for unsigned), record the result signs, clear the step counter, go to CALC.
  - `in1`/`in2` may change after this edge without effect.
- **CALC**: exactly 32 steps, counter 0..31, then go to FIX.
  - Multiply: shift-add over a 64-bit accumulator; one multiplier bit per step, LSB first.
  - Divide: restoring division; one quotient bit per step, MSB first. The partial remainder is 33 bits wide so the trial subtract cannot overflow.
- **FIX**: one cycle. Apply the sign correction, write HI/LO, go to IDLE.
  - Product sign = sign(in1) XOR sign(in2).
  - Quotient sign = sign(in1) XOR sign(in2).
  - Remainder sign follows the dividend.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
- Divide by zero (divisor 0): HI = `in1` unchanged, LO = 32'hFFFF_FFFF. Both signed and unsigned; still takes the full latency.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This is the natural wrap of the 33-bit path, not a special case.
- `start` while busy: ignored. No queueing.
- `hi_we`/`lo_we`:
  - In IDLE: write on that edge.
  - While busy: ignored.
  - In the same IDLE cycle as `start`: MTHI/MTLO write first. The later operation result then overwrites HI/LO.
- Reset, including mid-operation: state = IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0. Any operation in flight is discarded.

## Timing
- Call the start-sampling edge E0.
- `busy` = 1 in the cycles after E0 through E33; FIX completes on E33.
- `done` = 1 for exactly one cycle after E33. In that cycle `busy` = 0 and `hi`/`lo` hold the new result.
- Total latency from E0 to result visible: 34 cycles.
- `start` is accepted in the `done` cycle, so back-to-back operations run with no gap cycle.
- All outputs are registered; there is no combinational path from any input to an output.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings (`MDU_MULT`=0, `MDU_MULTU`=1, `MDU_DIV`=2, `MDU_DIVU`=3);
  - FSM state encodings;
  - `MDU_STEPS`=32.
- The ALU controller imports the same op constants when decoding Funct 0x18–0x1B.
- One sub-module, `mdu_step`: combinational single-iteration datapath. Inputs are mode, accumulator/remainder, and operand; outputs are the next accumulator/remainder and the quotient bit. The top level keeps the FSM, counter, sign fix and HI/LO registers.

## Test plan
- Basic multiply: MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `done` at cycle 34; HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- Signed multiply and divide:
  - MULT −3 × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
  - DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- Edge divides:
  - DIVU 100 / 0 → HI = 100, LO = 0xFFFF_FFFF.
  - DIV 0x8000_0000 / −1 → LO = 0x8000_0000, HI = 0.
- Handshake:
  - Pulse `start` at cycles 5 and 10 during one operation → the second is ignored and exactly one `done` appears.
  - `start` held in the `done` cycle → the next operation begins immediately; `busy` shows no gap.
- MTHI/MTLO:
  - `hi_we` with `in1` = 0x1234 in IDLE → `hi` = 0x1234 next cycle.
  - `lo_we` while busy → `lo` unchanged until the result is written.
- Reset: drive `reset` low at step 15 of a DIVU → next cycle `busy` = 0, `hi` = `lo` = 0. A fresh MULTU 6 × 7 then gives LO = 42.
